fifo_flex: RTL and testbench
============================

Name: fifo_flex

Overview:
- Parametrised successor to the basic synchronous FIFO: user-defined data width (BIT_WIDTH) and any depth ≥2, including non-power-of-two.
- Adds an occupancy count, programmable almost_full/almost_empty thresholds, sticky overflow/underflow error flags, and a defined simultaneous push+pop rule at full.
- Sits between byte/word producers and consumers (e.g. UART rx/tx paths) as the drop-in buffer for new datapaths.

Parameters:
DEPTH, 8, number of storage entries; any integer ≥2.
BIT_WIDTH, 8, data word width in bits.
AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
push  in  1  write request.
pop  in  1  read request.
push_data  in  BIT_WIDTH  write data, sampled on the accepted push edge.
pop_data  out  BIT_WIDTH  head-of-queue word (first-word fall-through).
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count ≥ AF_LEVEL.
almost_empty  out  1  count ≤ AE_LEVEL.
count  out  CW  occupancy, CW = $clog2(DEPTH+1).
overflow  out  1  sticky: push rejected while full.
underflow  out  1  sticky: pop requested while empty.
err_clr  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (async, rst=1): wptr=0, rptr=0, count=0; empty=1, full=0, almost_empty=1 (AE_LEVEL≥0), almost_full=0, overflow=0, underflow=0. Storage contents are not reset; pop_data is don't-care while empty. Reset mid-traffic discards all contents immediately.
- Pointers: width AW = max(1, $clog2(DEPTH)). Increment wraps explicitly from DEPTH-1 to 0; no reliance on power-of-two overflow.
- push_ok = push & (~full | pop). pop_ok = pop & ~empty.
- Write: on push_ok, mem[wptr] <= push_data; wptr advances.
- Read: pop_data = mem[rptr] combinationally, with zero-cycle latency (FWFT). On pop_ok, rptr advances. Data written at edge N is visible on pop_data after edge N when the FIFO was empty.
- count update: +1 when push_ok & ~pop_ok; -1 when pop_ok & ~push_ok; unchanged otherwise.
- Simultaneous events:
  - Full with push+pop: both accepted, count stays DEPTH, no overflow. The write slot equals the slot being freed; the read returns the old word.
  - Empty with push+pop: push accepted, pop ignored, underflow set, count becomes 1.
  - Push alone while full: data dropped, overflow <= 1.
  - Pop alone while empty: underflow <= 1; pointers unchanged.
- err_clr: clears both sticky flags at the edge. A new error in the same cycle takes priority (flag stays 1).
- Flags full, empty, almost_* are derived combinationally from the count register only (glitch-free relative to the clock), never from push/pop inputs.
- Elaboration checks: DEPTH<2, AF_LEVEL outside 1..DEPTH, or AE_LEVEL outside 0..DEPTH-1 fail via an initial $error.

Decomposition:
- Package fifo_pkg: function ptr_w(depth) = max(1,$clog2(depth)), function cnt_w(depth) = $clog2(depth+1). No typedefs beyond these.
- Sub-module fifo_mem: DEPTH×BIT_WIDTH register array, one write port (we, w_addr, w_data), one async read port.
- Pointer/count/flag logic lives in fifo_flex itself.

Test Plan:
- Reset then idle (DEPTH=5, AF=4, AE=1) -> empty=1, almost_empty=1, count=0, full=0, overflow=underflow=0.
- Push 0x11..0x15 (5 words) -> count 1..5; almost_empty drops after count=2; almost_full at count=4; full at 5. A 6th push of 0xFF sets overflow; count stays 5, contents unchanged.
- With DEPTH=5 full, 3 cycles push+pop (0xA1,0xA2,0xA3) -> pops return 0x11,0x12,0x13; count stays 5, no overflow. Draining yields 0x14,0x15,0xA1,0xA2,0xA3, exercising the 4→0 pointer wrap.
- Empty, pop -> underflow=1; then push+pop of 0x5A same cycle -> count=1, pop_data=0x5A; err_clr with no new error -> both flags 0.
- Push 0x77 on an empty FIFO -> pop_data=0x77 and empty=0 the cycle after the edge, demonstrating FWFT latency.
- Fill 3 words, assert rst asynchronously mid-cycle -> count=0 and empty=1 immediately (before next edge); subsequent push 0x33 reads back 0x33.

Source files
------------

// File: rtl/fifo_flex_pkg.sv
// fifo_pkg: sizing helpers shared by the fifo_flex slice.
//   ptr_w(depth) : pointer width, never below 1 bit (a 2-entry FIFO still needs one).
//   cnt_w(depth) : occupancy counter width, wide enough to hold the value depth itself.
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_flex_if.sv
// fifo_flex_if: push/pop handshake bundle between a user and fifo_flex.
//   master : user side; drives push, pop, push_data, err_clr.
//   slave  : FIFO side; drives pop_data, count, the status flags and the sticky errors.
//
// Handshake: a push is accepted on a rising edge when push=1 and (full=0 or pop=1).
// A pop is accepted on a rising edge when pop=1 and empty=0. pop_data always shows
// the head word (first-word fall-through), so the word consumed by an accepted pop
// is the one visible on pop_data just before that edge. Requests that are not
// accepted are not held pending; they are dropped and recorded in overflow/underflow.
interface fifo_flex_if
  import fifo_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int BIT_WIDTH = 8
) ();

  localparam int CW = cnt_w(DEPTH);

  logic                 push;
  logic                 pop;
  logic [BIT_WIDTH-1:0] push_data;
  logic [BIT_WIDTH-1:0] pop_data;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [CW-1:0]        count;
  logic                 overflow;
  logic                 underflow;
  logic                 err_clr;

  modport master (
    output push, pop, push_data, err_clr,
    input  pop_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  push, pop, push_data, err_clr,
    output pop_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_flex_mem.sv
// fifo_mem: DEPTH x BIT_WIDTH register array for fifo_flex.
//   clk    : write clock
//   we     : write enable
//   w_addr : write address (0..DEPTH-1)
//   w_data : write data
//   r_addr : read address (0..DEPTH-1)
//   r_data : asynchronous read data
// Contents are deliberately not reset.
module fifo_mem #(
  parameter int DEPTH     = 8,
  parameter int BIT_WIDTH = 8,
  parameter int AW        = 3
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        w_addr,
  input  logic [BIT_WIDTH-1:0] w_data,
  input  logic [AW-1:0]        r_addr,
  output logic [BIT_WIDTH-1:0] r_data
);

  logic [BIT_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_flex.sv
// fifo_flex: synchronous first-word fall-through FIFO of any depth >= 2.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset (pointers, count and error flags)
//   bus : fifo_flex_if.slave -- push/pop/push_data/err_clr in; pop_data, count,
//         full, empty, almost_full, almost_empty, overflow, underflow out.
// Parameters: DEPTH (>=2), BIT_WIDTH, AF_LEVEL (1..DEPTH), AE_LEVEL (0..DEPTH-1).
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int BIT_WIDTH = 8,
  parameter int AF_LEVEL  = DEPTH - 1,
  parameter int AE_LEVEL  = 1
) (
  input logic        clk,
  input logic        rst,
  fifo_flex_if.slave bus
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

  // Parameter legality is checked at elaboration.
  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_flex: DEPTH must be >= 2 (got %0d)", DEPTH);
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_flex: AF_LEVEL must be in 1..DEPTH (got %0d)", AF_LEVEL);
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_flex: AE_LEVEL must be in 0..DEPTH-1 (got %0d)", AE_LEVEL);
  end

  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q, underflow_q;

  logic full_w, empty_w;
  logic push_ok, pop_ok;
  logic ovf_evt, unf_evt;

  // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Status comes from the count register alone, never from the request inputs.
  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);

  // At full a simultaneous pop frees the slot the push lands in, so both proceed.
  assign push_ok = bus.push & (~full_w | bus.pop);
  assign pop_ok  = bus.pop & ~empty_w;
  assign ovf_evt = bus.push & full_w & ~bus.pop;
  assign unf_evt = bus.pop & empty_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= ptr_inc(wptr_q);
      if (pop_ok)  rptr_q <= ptr_inc(rptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky errors: a fresh error in the same cycle wins over err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (ovf_evt)          overflow_q <= 1'b1;
      else if (bus.err_clr) overflow_q <= 1'b0;
      if (unf_evt)          underflow_q <= 1'b1;
      else if (bus.err_clr) underflow_q <= 1'b0;
    end
  end

  fifo_mem #(
    .DEPTH     (DEPTH),
    .BIT_WIDTH (BIT_WIDTH),
    .AW        (AW)
  ) u_mem (
    .clk    (clk),
    .we     (push_ok),
    .w_addr (wptr_q),
    .w_data (bus.push_data),
    .r_addr (rptr_q),
    .r_data (bus.pop_data)
  );

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= CNT_AF);
  assign bus.almost_empty = (count_q <= CNT_AE);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: directed bench for fifo_flex with DEPTH=5, AF_LEVEL=4, AE_LEVEL=1.
module tb_fifo_flex;

  localparam int DEPTH = 5;
  localparam int BW    = 8;

  logic clk;
  logic rst;

  int n_total = 0;
  int n_bad   = 0;

  logic [BW-1:0] exp_q[$];

  fifo_flex_if #(.DEPTH(DEPTH), .BIT_WIDTH(BW)) bus ();

  fifo_flex #(
    .DEPTH     (DEPTH),
    .BIT_WIDTH (BW),
    .AF_LEVEL  (4),
    .AE_LEVEL  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input int cnt, input logic e, input logic f,
                              input logic ae, input logic af);
    check({tag, ".count"}, 32'(bus.count), 32'(cnt));
    check({tag, ".empty"}, 32'(bus.empty), 32'(e));
    check({tag, ".full"},  32'(bus.full),  32'(f));
    check({tag, ".ae"},    32'(bus.almost_empty), 32'(ae));
    check({tag, ".af"},    32'(bus.almost_full),  32'(af));
  endtask

  // ---------------- drivers ----------------
  // Inputs are applied 1 time unit after a rising edge and held for one edge.
  task automatic step(input logic p, input logic q, input logic [BW-1:0] d, input logic clr);
    bus.push      = p;
    bus.pop       = q;
    bus.push_data = d;
    bus.err_clr   = clr;
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  // Pop one word, checking the head against the expected queue before the edge.
  task automatic pop_check(input string tag);
    logic [BW-1:0] e;
    e = exp_q.pop_front();
    check(tag, 32'(bus.pop_data), 32'(e));
    step(1'b0, 1'b1, '0, 1'b0);
  endtask

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.push_data = '0; bus.err_clr = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset / idle
    check_status("reset", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("reset.ovf", 32'(bus.overflow), 32'd0);
    check("reset.unf", 32'(bus.underflow), 32'd0);

    // Fill 0x11..0x15
    step(1'b1, 1'b0, 8'h11, 1'b0); check_status("fill1", 1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("fill1.fwft", 32'(bus.pop_data), 32'h11);
    step(1'b1, 1'b0, 8'h12, 1'b0); check_status("fill2", 2, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h13, 1'b0); check_status("fill3", 3, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h14, 1'b0); check_status("fill4", 4, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h15, 1'b0); check_status("fill5", 5, 1'b0, 1'b1, 1'b0, 1'b1);

    // Push while full is dropped
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    check_status("ovf", 5, 1'b0, 1'b1, 1'b0, 1'b1);
    check("ovf.flag", 32'(bus.overflow), 32'd1);
    check("ovf.head", 32'(bus.pop_data), 32'h11);

    step(1'b0, 1'b0, '0, 1'b1);
    check("ovf.clr", 32'(bus.overflow), 32'd0);

    // Push+pop at full: old words come out, count stays DEPTH
    exp_q = '{8'h11, 8'h12, 8'h13};
    check("pp1.head", 32'(bus.pop_data), 32'(exp_q.pop_front()));
    step(1'b1, 1'b1, 8'hA1, 1'b0);
    check("pp1.count", 32'(bus.count), 32'd5);
    check("pp2.head", 32'(bus.pop_data), 32'(exp_q.pop_front()));
    step(1'b1, 1'b1, 8'hA2, 1'b0);
    check("pp3.head", 32'(bus.pop_data), 32'(exp_q.pop_front()));
    step(1'b1, 1'b1, 8'hA3, 1'b0);
    check_status("pp3", 5, 1'b0, 1'b1, 1'b0, 1'b1);
    check("pp3.ovf", 32'(bus.overflow), 32'd0);

    // Drain across the 4->0 pointer wrap
    exp_q = '{8'h14, 8'h15, 8'hA1, 8'hA2, 8'hA3};
    pop_check("drain0"); check("drain0.count", 32'(bus.count), 32'd4);
    pop_check("drain1");
    pop_check("drain2");
    pop_check("drain3"); check_status("drain3", 1, 1'b0, 1'b0, 1'b1, 1'b0);
    pop_check("drain4"); check_status("drain4", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("drain.unf", 32'(bus.underflow), 32'd0);

    // Pop while empty
    step(1'b0, 1'b1, '0, 1'b0);
    check("unf.flag", 32'(bus.underflow), 32'd1);
    check("unf.count", 32'(bus.count), 32'd0);

    // Push+pop while empty: push wins, pop is an underflow
    step(1'b1, 1'b1, 8'h5A, 1'b0);
    check("epp.count", 32'(bus.count), 32'd1);
    check("epp.data", 32'(bus.pop_data), 32'h5A);
    check("epp.unf", 32'(bus.underflow), 32'd1);

    step(1'b0, 1'b0, '0, 1'b1);
    check("clr.unf", 32'(bus.underflow), 32'd0);
    check("clr.ovf", 32'(bus.overflow), 32'd0);

    exp_q.push_back(8'h5A);
    pop_check("epp.pop");
    check("epp.empty", 32'(bus.empty), 32'd1);

    // New error in the same cycle as err_clr keeps the flag set
    step(1'b0, 1'b1, '0, 1'b1);
    check("clr_vs_err", 32'(bus.underflow), 32'd1);
    step(1'b0, 1'b0, '0, 1'b1);
    check("clr2", 32'(bus.underflow), 32'd0);

    // FWFT latency from empty
    step(1'b1, 1'b0, 8'h77, 1'b0);
    check("fwft.data", 32'(bus.pop_data), 32'h77);
    check("fwft.empty", 32'(bus.empty), 32'd0);
    exp_q.push_back(8'h77);
    pop_check("fwft.pop");

    // Asynchronous reset in the middle of a cycle
    step(1'b1, 1'b0, 8'h01, 1'b0);
    step(1'b1, 1'b0, 8'h02, 1'b0);
    step(1'b1, 1'b0, 8'h03, 1'b0);
    check("pre_rst.count", 32'(bus.count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check_status("async_rst", 0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 8'h33, 1'b0);
    check("post_rst.data", 32'(bus.pop_data), 32'h33);
    check("post_rst.count", 32'(bus.count), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
